// File: rtl/fmul_arb_pkg.sv
// Shared types and latency constants for the fmul arbiter slice.
// Tag width is sized for the largest supported requester count (8).
package fmul_arb_pkg;

    localparam int FMUL_LAT = 2;
    localparam int ARB_LAT  = 3;
    localparam int TAG_MAXW = 3;

    typedef struct packed {
        logic                valid;
        logic [TAG_MAXW-1:0] tag;
    } tag_stage_t;

endpackage

// File: rtl/fmul_arb_if.sv
// Request/response bundle between N issue ports and the shared multiplier arbiter.
interface fmul_arb_if #(
    parameter int N = 4
);
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [32*N-1:0] req_x1;
    logic [32*N-1:0] req_x2;
    logic [N-1:0]    resp_valid;
    logic [31:0]     resp_y;
    logic            busy;

    modport master (
        output req_valid, req_x1, req_x2,
        input  req_ready, resp_valid, resp_y, busy
    );

    modport slave (
        input  req_valid, req_x1, req_x2,
        output req_ready, resp_valid, resp_y, busy
    );
endinterface

// File: rtl/fmul.sv
// Two-stage single-precision multiplier: sign XOR, zero-exponent flush to signed zero,
// round-half-up on the first dropped bit, no NaN/Inf handling.
module fmul (
    input  logic        clk,
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    output logic [31:0] y
);
    logic        sign_reg;
    logic        zero_reg;
    logic [9:0]  exp_reg;
    logic [47:0] prod_reg;

    always_ff @(posedge clk) begin
        sign_reg <= x1[31] ^ x2[31];
        zero_reg <= (x1[30:23] == 8'd0) || (x2[30:23] == 8'd0);
        exp_reg  <= {2'b00, x1[30:23]} + {2'b00, x2[30:23]} - 10'd127;
        prod_reg <= 48'({1'b1, x1[22:0]}) * 48'({1'b1, x2[22:0]});
    end

    logic [22:0] mant_pre;
    logic        round_bit;
    logic [9:0]  exp_adj;
    logic [22:0] mant_fin;
    logic        mant_carry;
    logic [9:0]  exp_fin;
    logic [31:0] y_next;

    // Product of two 1.x mantissas lies in [1,4); bit 47 selects the normalisation shift.
    always_comb begin
        mant_pre  = prod_reg[45:23];
        round_bit = prod_reg[22];
        exp_adj   = exp_reg;
        if (prod_reg[47]) begin
            mant_pre  = prod_reg[46:24];
            round_bit = prod_reg[23];
            exp_adj   = exp_reg + 10'd1;
        end
        {mant_carry, mant_fin} = {1'b0, mant_pre} + 24'(round_bit);
        exp_fin = exp_adj + 10'(mant_carry);
        y_next  = zero_reg ? {sign_reg, 31'd0} : {sign_reg, exp_fin[7:0], mant_fin};
    end

    always_ff @(posedge clk) begin
        y <= y_next;
    end

    logic unused_bits;
    assign unused_bits = ^{prod_reg[21:0], exp_fin[9:8]};

endmodule

// File: rtl/fmul_arb_pick.sv
// Combinational request picker. FMUL_ARB_RR_EN selects round-robin after ptr;
// otherwise the lowest requesting index wins and ptr is ignored.
module fmul_arb_pick #(
    parameter int N    = 4,
    parameter int TAGW = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [TAGW-1:0] ptr,
    output logic [N-1:0]    gnt,
    output logic [TAGW-1:0] idx
);
`ifdef FMUL_ARB_RR_EN
    logic            found;
    logic [TAGW-1:0] cand;

    // Walk ptr+1 .. ptr+N so the last winner drops to lowest priority.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 1; k <= N; k++) begin
            cand = TAGW'((int'(ptr) + k) % N);
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end
`else
    // Descending scan: the final hit is the lowest index.
    always_comb begin
        gnt = '0;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                gnt    = '0;
                gnt[i] = 1'b1;
                idx    = TAGW'(i);
            end
        end
    end

    logic unused_ptr;
    assign unused_ptr = ^ptr;
`endif
endmodule

// File: rtl/fmul_arb.sv
// Shares one pipelined fmul among N requesters; a tag pipeline routes each product back.
// Define FMUL_ARB_RR_EN for round-robin arbitration, otherwise fixed priority.
module fmul_arb
    import fmul_arb_pkg::*;
#(
    parameter int N    = 4,
    parameter int TAGW = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    fmul_arb_if.slave    bus
);
    logic [N-1:0]    gnt;
    logic [TAGW-1:0] idx;
    logic [TAGW-1:0] ptr;
    logic            xfer;
    logic [31:0]     x1_arr [N];
    logic [31:0]     x2_arr [N];

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_slice
            assign x1_arr[gi] = bus.req_x1[32*gi +: 32];
            assign x2_arr[gi] = bus.req_x2[32*gi +: 32];
        end
    endgenerate

    fmul_arb_pick #(.N(N), .TAGW(TAGW)) u_pick (
        .req (bus.req_valid),
        .ptr (ptr),
        .gnt (gnt),
        .idx (idx)
    );

    assign bus.req_ready = rst ? '0 : gnt;
    assign xfer          = |bus.req_ready;

`ifdef FMUL_ARB_RR_EN
    logic [TAGW-1:0] ptr_reg;

    // Starting at N-1 makes requester 0 first in line after reset.
    always_ff @(posedge clk) begin
        if (rst)
            ptr_reg <= TAGW'(N - 1);
        else if (xfer)
            ptr_reg <= idx;
    end
    assign ptr = ptr_reg;
`else
    assign ptr = '0;
`endif

    // Operands are only loaded on a transfer; stale values are masked by the tag valid bit.
    logic [31:0] x1_reg;
    logic [31:0] x2_reg;

    always_ff @(posedge clk) begin
        if (xfer) begin
            x1_reg <= x1_arr[idx];
            x2_reg <= x2_arr[idx];
        end
    end

    logic [31:0] y;

    fmul u_fmul (
        .clk (clk),
        .x1  (x1_reg),
        .x2  (x2_reg),
        .y   (y)
    );

    // Stage 0 sits beside the issue register; stage FMUL_LAT lines up with fmul.y.
    tag_stage_t pipe_reg [ARB_LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < ARB_LAT; s++)
                pipe_reg[s] <= '0;
        end else begin
            pipe_reg[0] <= '{valid: xfer, tag: TAG_MAXW'(idx)};
            for (int s = 1; s < ARB_LAT; s++)
                pipe_reg[s] <= pipe_reg[s-1];
        end
    end

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_resp
            assign bus.resp_valid[gi] = pipe_reg[FMUL_LAT].valid &&
                                        (pipe_reg[FMUL_LAT].tag == TAG_MAXW'(gi));
        end
    endgenerate

    assign bus.resp_y = y;

    logic busy_next;

    always_comb begin
        busy_next = 1'b0;
        for (int s = 0; s < ARB_LAT; s++)
            busy_next = busy_next | pipe_reg[s].valid;
    end

    assign bus.busy = busy_next;

endmodule

// File: tb/tb_fmul_arb.sv
// Directed bench for fmul_arb: handshakes push expected products into a scoreboard
// queue, the negedge monitor pops and compares each response.
module tb_fmul_arb;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fmul_arb_if #(.N(N)) bus ();

    fmul_arb #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int          due;
        logic [N-1:0] who;
        logic [31:0] y;
    } exp_t;

    exp_t        sbq [$];
    exp_t        mon_e;
    logic [31:0] exp_tab [N];
    int          checks = 0;
    int          errors = 0;
    int          cycle  = 0;
    int          n0;
    logic [N-1:0] exp_gnt;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h cycle=%0d", tag, obs, expv, cycle);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] expy);
        bus.req_valid[i]          = 1'b1;
        bus.req_x1[32*i +: 32]    = a;
        bus.req_x2[32*i +: 32]    = b;
        exp_tab[i]                = expy;
    endtask

    // Scoreboard: record handshakes, then match responses in order.
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (bus.req_valid[i] && bus.req_ready[i])
                sbq.push_back('{due: cycle + 3, who: N'(1) << i, y: exp_tab[i]});
        end
        if (bus.resp_valid != '0) begin
            if (sbq.size() == 0) begin
                chk("unexpected_resp", 32'(bus.resp_valid), 32'(0));
            end else begin
                mon_e = sbq.pop_front();
                chk("resp_cycle", 32'(cycle), 32'(mon_e.due));
                chk("resp_valid", 32'(bus.resp_valid), 32'(mon_e.who));
                chk("resp_y", bus.resp_y, mon_e.y);
                $display("resp cycle=%0d who=%b y=%h", cycle, bus.resp_valid, bus.resp_y);
            end
        end else if (sbq.size() > 0 && sbq[0].due <= cycle) begin
            chk("resp_missing", 32'(bus.resp_valid), 32'(sbq[0].who));
            void'(sbq.pop_front());
        end
    end

    initial begin
        bus.req_valid = '0;
        bus.req_x1    = '0;
        bus.req_x2    = '0;
        for (int i = 0; i < N; i++) exp_tab[i] = '0;

        // Reset: grant forced low even with every requester pending.
        tick();
        tick();
        bus.req_valid = '1;
        @(negedge clk);
        chk("reset_ready", 32'(bus.req_ready), 32'(0));
        chk("reset_resp_valid", 32'(bus.resp_valid), 32'(0));
        chk("reset_busy", 32'(bus.busy), 32'(0));
        tick();
        rst = 1'b0;
        bus.req_valid = '0;
        tick();

        // Single requester, busy window n+1..n+3.
        drive(0, 32'h3F800000, 32'h40000000, 32'h40000000);
        @(negedge clk);
        n0 = cycle;
        chk("single_ready", 32'(bus.req_ready), 32'(4'b0001));
        tick();
        bus.req_valid = '0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk("single_busy_hi", 32'(bus.busy), 32'(1));
            if (k == 3) chk("single_resp_valid", 32'(bus.resp_valid), 32'(4'b0001));
            tick();
        end
        @(negedge clk);
        chk("single_busy_lo", 32'(bus.busy), 32'(0));
        chk("single_latency", 32'(cycle), 32'(n0 + 4));

        // Back-to-back from two requesters.
        tick();
        drive(1, 32'h3FC00000, 32'h3FC00000, 32'h40100000);
        @(negedge clk);
        chk("b2b_ready1", 32'(bus.req_ready), 32'(4'b0010));
        tick();
        bus.req_valid = '0;
        drive(2, 32'h40400000, 32'hC0000000, 32'hC0C00000);
        @(negedge clk);
        chk("b2b_ready2", 32'(bus.req_ready), 32'(4'b0100));
        tick();
        bus.req_valid = '0;
        repeat (4) tick();

        // Rounding, signed zero, zero; last grant lands on requester 3.
        drive(2, 32'h3F800001, 32'h3FC00000, 32'h3FC00002);
        tick();
        bus.req_valid = '0;
        drive(0, 32'h00000000, 32'hC0400000, 32'h80000000);
        tick();
        bus.req_valid = '0;
        drive(3, 32'h00000000, 32'h40400000, 32'h00000000);
        tick();
        bus.req_valid = '0;
        repeat (4) tick();

        // Contention: all requesters pending for 8 cycles.
        for (int i = 0; i < N; i++)
            drive(i, 32'((127 + i) << 23) | 32'h00400000, 32'h3F800000,
                  32'((127 + i) << 23) | 32'h00400000);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
`ifdef FMUL_ARB_RR_EN
            exp_gnt = N'(1) << (k % N);
`else
            exp_gnt = N'(1);
`endif
            chk("contention_grant", 32'(bus.req_ready), 32'(exp_gnt));
            tick();
        end
        bus.req_valid = '0;
        repeat (5) tick();

        // Reset with two operations in flight.
        drive(1, 32'h3F800000, 32'h40000000, 32'h40000000);
        tick();
        bus.req_valid = '0;
        drive(2, 32'h40000000, 32'h40000000, 32'h40800000);
        tick();
        bus.req_valid = '0;
        rst = 1'b1;
        sbq.delete();
        @(negedge clk);
        chk("rst_mid_resp0", 32'(bus.resp_valid), 32'(0));
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_resp1", 32'(bus.resp_valid), 32'(0));
        chk("rst_mid_busy", 32'(bus.busy), 32'(0));
        tick();
        drive(3, 32'h40400000, 32'h40400000, 32'h41100000);
        @(negedge clk);
        chk("rst_mid_resp2", 32'(bus.resp_valid), 32'(0));
        chk("rst_mid_ready", 32'(bus.req_ready), 32'(4'b1000));
        tick();
        bus.req_valid = '0;
        @(negedge clk);
        chk("rst_mid_resp3", 32'(bus.resp_valid), 32'(0));
        repeat (5) tick();

        @(negedge clk);
        chk("queue_drained", 32'(sbq.size()), 32'(0));
        chk("final_busy", 32'(bus.busy), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fmul_arb.md
# fmul_arb

Shares one pipelined `fmul` instance among N requesters with a valid/ready request handshake. The block selects one request per cycle, either round-robin or fixed-priority, and registers its operands into the multiplier. It carries a requester tag alongside the multiplier pipeline and returns each product to its requester as a one-cycle response pulse. It sits between the FPU issue ports, such as per-lane or per-thread register-read stages, and the single-precision multiplier.

## Interface
- `N`, 4: number of requesters, 2..8.
- `TAGW`, `$clog2(N)`: tag width, derived; do not override.

- `clk`, in, 1: the single clock.
- `rst`, in, 1: reset. Synchronous and active-high.
- `req_valid`, in, N: request pending, one bit per requester.
- `req_ready`, out, N: one-hot grant. A transfer completes when `req_valid[i] & req_ready[i]`.
- `req_x1`, in, 32*N: operand 1 for each requester. Slice i is bits [32i+31:32i].
- `req_x2`, in, 32*N: operand 2 for each requester, same slicing.
- `resp_valid`, out, N: one-hot, one-cycle pulse marking a returned product.
- `resp_y`, out, 32: product for the requester flagged in `resp_valid`.
- `busy`, out, 1: high while any accepted operation is still in flight.

## Operation
- **Request rules.** A requester holds `req_valid` and its operands stable until it sees `req_ready`. Operands may change freely after the transfer.
- **Grant.**
  - `req_ready` is combinational from `req_valid` and the priority state.
  - At most one bit is set, and only when some `req_valid` bit is high.
  - The block never stalls, so it accepts one request every cycle.
- **Accept.** On a transfer, at the next edge:
  - the issue register captures `req_x1`/`req_x2` of the winner;
  - the tag pipeline stage 0 captures `{valid=1, tag=i}`.
- **Idle cycles.** With no transfer, stage 0 loads valid=0. Operand registers may keep stale values, because `fmul` output is ignored when valid=0.
- **Tag pipeline.** The tag pipeline has 3 stages (0, 1, 2). Stage 2 lines up with `fmul.y` for the same operation.
- **Response.**
  - `resp_valid = stage2.valid ? onehot(stage2.tag) : 0`.
  - `resp_y = fmul.y`.
- **No response backpressure.** Requesters must always accept `resp_valid`.
- **`busy`** is the OR of the three stage valid bits.
- **Arithmetic** is `fmul` unchanged:
  - the operand sign is XORed into the result;
  - an operand with exponent 0 gives a signed zero;
  - no NaN/Inf handling;
  - round-half-up on the dropped bit.
- **Reset.**
  - On `rst`: all stage valid bits clear, so `resp_valid=0` and `busy=0`, and the priority pointer resets to N-1.
  - `req_ready` stays combinational; `rst` forces it to 0 that cycle.
  - Operations in flight at reset are dropped and never reported.
  - The first response after reset deasserts comes from a request accepted after it.

## Timing
- **Latency.** A handshake in cycle n gives `resp_valid` for that requester in cycle n+3. The path is:
  - edge n→n+1: issue register and tag stage 0;
  - edge n+1→n+2: `fmul` stage 1 and tag stage 1;
  - edge n+2→n+3: `fmul` output and tag stage 2.
- **Throughput.** One operation per cycle. Back-to-back handshakes in cycles n and n+1 produce responses in cycles n+3 and n+4.
- **Ordering.** Responses come back in acceptance order. Each accepted request yields exactly one response.
- **Handshake timing.** `req_ready` may drop in the same cycle `req_valid` drops. There is no ready-before-valid dependency.

## Configuration
- **`FMUL_ARB_RR_EN` defined:** round-robin.
  - A pointer holds the last granted index.
  - Search order is pointer+1, pointer+2, … modulo N.
  - The pointer updates only on a transfer.
  - After reset requester 0 has highest priority.
- **Undefined:** fixed priority. The lowest index wins, and the pointer register is not built.

## Structure
- **Package `fmul_arb_pkg`:** tag-stage struct `{logic valid; logic [TAGW-1:0] tag;}`, constants `FMUL_LAT=2` and `ARB_LAT=3`.
- **Sub-module `fmul_arb_pick`** (combinational):
  - inputs `req` [N] and `ptr` [TAGW];
  - outputs one-hot `gnt` and encoded `idx`;
  - contains both the round-robin and fixed-priority variants under the macro.
- **Existing `fmul`** is instantiated unmodified.

## Test plan
- **Single requester.** Req 0 sends `3F800000`×`40000000` in cycle 5 → `resp_valid=0001` with `resp_y=40000000` in cycle 8, `busy` high in cycles 6–8.
- **Back-to-back streaming.**
  - Stimulus: req 1 sends `3FC00000`×`3FC00000` in cycle 5, then req 2 sends `40400000`×`C0000000` in cycle 6.
  - Response: `resp_y=40100000` to req 1 in cycle 8, then `C0C00000` to req 2 in cycle 9.
- **Zero operand.** `00000000`×`40400000` → `resp_y=00000000`.
- **Contention.**
  - Stimulus: all 4 requesters hold valid continuously for 8 cycles.
  - With `FMUL_ARB_RR_EN`: grant order 0,1,2,3,0,1,2,3.
  - Without it: 0 is granted every cycle.
- **Reset mid-flight.**
  - Stimulus: accept in cycles 5 and 6, assert `rst` in cycle 7.
  - Response: no `resp_valid` in cycles 7–10, `busy=0` from cycle 8, and a new request in cycle 9 returns in cycle 12.
